// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO with registered
//               full/empty flags. Optional occupancy output under FIFO_LEVEL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty
`ifdef FIFO_LEVEL_EN
  ,
  output logic [ASIZE:0]   level
`endif
);

  localparam int               c_DEPTH   = 1 << ASIZE;
  localparam logic [ASIZE:0]   c_PTR_ONE = {{ASIZE{1'b0}}, 1'b1};

  logic [DSIZE-1:0] r_mem [c_DEPTH];

  logic [ASIZE:0]   r_wptr;
  logic [ASIZE:0]   r_rptr;
  logic [ASIZE:0]   w_wptr_nxt;
  logic [ASIZE:0]   w_rptr_nxt;
  logic             r_wfull;
  logic             r_rempty;
  logic             w_wr_en;
  logic             w_rd_en;
  logic [ASIZE-1:0] w_waddr;
  logic [ASIZE-1:0] w_raddr;

  // Requests are qualified by the pre-edge flags, so a full FIFO still pops
  // on a simultaneous read/write and an empty one still pushes.
  assign w_wr_en = winc & ~r_wfull;
  assign w_rd_en = rinc & ~r_rempty;
  assign w_waddr = r_wptr[ASIZE-1:0];
  assign w_raddr = r_rptr[ASIZE-1:0];

  always_comb begin
    w_wptr_nxt = r_wptr;
    w_rptr_nxt = r_rptr;
    if (w_wr_en) w_wptr_nxt = r_wptr + c_PTR_ONE;
    if (w_rd_en) w_rptr_nxt = r_rptr + c_PTR_ONE;
  end

  // Flags are evaluated on the next-state pointers so they never lag them.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_rempty <= 1'b1;
      r_wfull  <= 1'b0;
    end else begin
      r_wptr   <= w_wptr_nxt;
      r_rptr   <= w_rptr_nxt;
      r_rempty <= (w_wptr_nxt == w_rptr_nxt);
      r_wfull  <= (w_wptr_nxt[ASIZE] != w_rptr_nxt[ASIZE]) &&
                  (w_wptr_nxt[ASIZE-1:0] == w_rptr_nxt[ASIZE-1:0]);
    end
  end

  always_ff @(posedge wclk) begin
    if (w_wr_en) r_mem[w_waddr] <= wdata;
  end

  assign rdata  = r_rempty ? '0 : r_mem[w_raddr];
  assign rempty = r_rempty;
  assign wfull  = r_wfull;

`ifdef FIFO_LEVEL_EN
  logic [ASIZE:0] r_level;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) r_level <= '0;
    else         r_level <= w_wptr_nxt - w_rptr_nxt;
  end

  assign level = r_level;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// ============================================================================
// Module      : tb_sync_fifo
// Description : Directed self-checking bench for sync_fifo (default build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo;

  logic       wclk;
  logic       wrst_n;
  logic [7:0] wdata;
  logic       winc;
  logic       wfull;
  logic       rinc;
  logic [7:0] rdata;
  logic       rempty;

  int         n_vec;
  int         n_miss;
  logic [7:0] q[$];
  logic [7:0] burst[8];

  sync_fifo #(.DSIZE(8), .ASIZE(4)) u_dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .wdata  (wdata),
    .winc   (winc),
    .wfull  (wfull),
    .rinc   (rinc),
    .rdata  (rdata),
    .rempty (rempty)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0] head;
    head = (q.size() != 0) ? q[0] : 8'h00;
    check({tag, ".rempty"}, 32'(rempty), 32'(q.size() == 0));
    check({tag, ".wfull"},  32'(wfull),  32'(q.size() == 16));
    check({tag, ".rdata"},  32'(rdata),  32'(head));
  endtask

  // One clock: drive requests, take the edge, update the reference queue.
  task automatic cyc(input string tag, input logic w, input logic [7:0] d, input logic r);
    int         n;
    logic [7:0] tmp;
    winc  = w;
    wdata = d;
    rinc  = r;
    n     = q.size();
    @(posedge wclk);
    #1;
    if (r && n > 0) tmp = q.pop_front();
    if (w && n < 16) q.push_back(d);
    winc = 1'b0;
    rinc = 1'b0;
    check_state(tag);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    wrst_n = 1'b1;
    winc   = 1'b0;
    rinc   = 1'b0;
    wdata  = 8'h00;

    // Asynchronous reset assertion between edges
    @(posedge wclk);
    #1;
    wrst_n = 1'b0;
    #2;
    check("rst.rempty", 32'(rempty), 32'd1);
    check("rst.wfull",  32'(wfull),  32'd0);
    check("rst.rdata",  32'(rdata),  32'd0);
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    check_state("rst_rel");

    // Burst of 8 random words
    for (int i = 0; i < 8; i++) burst[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) cyc("burst_wr", 1'b1, burst[i], 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("burst_head", 32'(rdata), 32'(burst[i]));
      cyc("burst_rd", 1'b0, 8'h00, 1'b1);
    end
    check("burst_empty", 32'(rempty), 32'd1);

    // Fill to 16, then a dropped 17th write
    for (int i = 0; i < 16; i++) begin
      check("fill_notfull", 32'(wfull), 32'd0);
      cyc("fill_wr", 1'b1, 8'(i), 1'b0);
    end
    check("fill_full", 32'(wfull), 32'd1);
    cyc("fill_drop", 1'b1, 8'hAA, 1'b0);
    check("fill_still_full", 32'(wfull), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("drain_head", 32'(rdata), 32'(i));
      cyc("drain_rd", 1'b0, 8'h00, 1'b1);
      check("drain_notfull", 32'(wfull), 32'd0);
    end
    check("drain_empty", 32'(rempty), 32'd1);
    check("drain_rdata0", 32'(rdata), 32'd0);

    // Underflow
    for (int i = 0; i < 3; i++) cyc("uflow", 1'b0, 8'h00, 1'b1);
    check("uflow_rdata", 32'(rdata), 32'd0);
    cyc("uflow_wr", 1'b1, 8'h5A, 1'b0);
    check("uflow_head", 32'(rdata), 32'h5A);
    cyc("uflow_rd", 1'b0, 8'h00, 1'b1);

    // Simultaneous push/pop at occupancy 5, across pointer wraps
    for (int i = 0; i < 5; i++) cyc("sim_pre", 1'b1, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc("sim_rw", 1'b1, 8'(8'h20 + i), 1'b1);
      check("sim_occ5", 32'(q.size()), 32'd5);
    end
    // Remaining stored words are 0x20+35 .. 0x20+39
    check("sim_head", 32'(rdata), 32'h43);
    for (int i = 0; i < 11; i++) cyc("sim_fill", 1'b1, 8'(8'h80 + i), 1'b0);
    check("sim_full", 32'(wfull), 32'd1);
    cyc("sim_full_rw", 1'b1, 8'hEE, 1'b1);
    check("sim_full_pop", 32'(wfull), 32'd0);
    check("sim_full_head", 32'(rdata), 32'h44);
    while (q.size() != 0) cyc("sim_drain", 1'b0, 8'h00, 1'b1);
    check("sim_drain_empty", 32'(rempty), 32'd1);

    // Reset with 9 words stored
    for (int i = 0; i < 9; i++) cyc("mrst_wr", 1'b1, 8'(8'h30 + i), 1'b0);
    check("mrst_pre_head", 32'(rdata), 32'h30);
    wrst_n = 1'b0;
    q.delete();
    #1;
    check("mrst.rempty", 32'(rempty), 32'd1);
    check("mrst.wfull",  32'(wfull),  32'd0);
    check("mrst.rdata",  32'(rdata),  32'd0);
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    cyc("mrst_wr1", 1'b1, 8'h77, 1'b0);
    check("mrst_head", 32'(rdata), 32'h77);
    cyc("mrst_rd1", 1'b0, 8'h00, 1'b1);
    check("mrst_final_empty", 32'(rempty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
